shift_dispatch: RTL and testbench
=================================

SHIFT_DISPATCH -- requirements
Module: shift_dispatch

Interface
REQ-001 Parameters: DATA_WIDTH, 64, operand/result width (fixed at 64 for eBPF); TIMEOUT_CYCLES, 16, ack watchdog limit when the watchdog is compiled in.
REQ-002 Ports: clk  in  1  single clock, all logic on rising edge; rst  in  1  reset, synchronous, active-high.
REQ-003 Ports: in_valid in 1 instruction offered; in_ready out 1 dispatch can accept; opcode in 8 eBPF opcode; dst_val in 64 dst register; src_val in 64 src register; imm in 32 instruction immediate.
REQ-004 Ports: sh_stb out 1 shifter strobe; sh_arith out 1 arithmetic right; sh_left out 1 left shift; sh_value out 64 operand; sh_shift out 64 shift amount; sh_out in 64 shifter result; sh_ack in 1 shifter done.
REQ-005 Ports: res_valid out 1 result available; res_ready in 1 consumer accepts; res_data out 64 writeback value; res_err out 1 illegal opcode or timeout.

Function
REQ-006 Opcode fields: class = opcode[2:0] (0x4 ALU32, 0x7 ALU64); src = opcode[3] (1 = src_val, 0 = imm sign-extended to 64); op = opcode[7:4] (0x6 LSH, 0x7 RSH, 0xC ARSH).
REQ-007 FSM states: IDLE, ISSUE, WAIT, DONE; in_ready = 1 only in IDLE.
REQ-008 IDLE: on in_valid, register operands/controls and go to ISSUE, or go to DONE with res_err=1, res_data=0 if class or op is not listed in REQ-006; sh_stb never asserted for illegal opcodes.
REQ-009 ISSUE: sh_stb=1 for exactly one cycle, then WAIT; sh_stb=0 in all other states.
REQ-010 sh_value, sh_shift, sh_left, sh_arith are registers, held constant from ISSUE until sh_ack is sampled.
REQ-011 sh_left=1 for LSH; sh_arith=1 for ARSH only.
REQ-012 ALU64: sh_value=dst_val; sh_shift = amount & 63, zero-extended.
REQ-013 ALU32: sh_shift = amount & 31; sh_value = {32{dst_val[31]}, dst_val[31:0]} for ARSH, {32'b0, dst_val[31:0]} otherwise.
REQ-014 WAIT: on sh_ack, capture res_data (ALU64: sh_out; ALU32: {32'b0, sh_out[31:0]}), res_err=0, go to DONE; sh_ack in any other state is ignored.
REQ-015 DONE: res_valid=1, res_data/res_err stable until res_ready; on res_valid&res_ready return to IDLE; next instruction accepted no earlier than the following cycle.
REQ-016 Latency, legal opcode: accept at edge N, sh_stb in cycle N+1, res_valid one cycle after sh_ack is sampled (cycle N+4 with a standard 2-cycle shifter).
REQ-017 Illegal opcode: res_valid asserted in the cycle after accept.

Reset
REQ-018 rst dominates all other inputs; outputs in and after the reset cycle: in_ready=1 (IDLE), sh_stb=0, res_valid=0, res_err=0, res_data=0, sh_value=0, sh_shift=0, sh_left=0, sh_arith=0.
REQ-019 Reset during ISSUE/WAIT/DONE abandons the instruction; a late sh_ack arriving in IDLE is ignored.

Configuration
REQ-020 With SHIFT_TIMEOUT_EN defined: a counter runs in WAIT; if sh_ack is absent for TIMEOUT_CYCLES cycles, go to DONE with res_err=1, res_data=0; the counter clears on entry to WAIT.
REQ-021 Without SHIFT_TIMEOUT_EN: no counter logic is present; WAIT holds indefinitely until sh_ack or rst.

Structure
REQ-022 Shared eBPF package holds opcode class constants (ALU32, ALU64), op constants (LSH, RSH, ARSH), the SRC bit position and the FSM state enum.
REQ-023 One sub-module, shift_operand_prep: combinational opcode decode plus the operand/amount formation of REQ-012/013; the FSM stays in shift_dispatch.

Verification
REQ-024 ALU64 LSH reg (0x6F), dst=0x1, src=0x43 -> sh_shift=3, res_data=0x8, res_err=0.
REQ-025 ALU32 ARSH imm (0xC4), dst=0xFFFF_FFFF_8000_0000, imm=4 -> sh_value=0xFFFF_FFFF_8000_0000, res_data=0x0000_0000_F800_0000.
REQ-026 ALU32 RSH reg (0x7C), dst=0xAAAA_AAAA_0000_0010, src=0x24 -> sh_shift=4, res_data=0x1.
REQ-027 Opcode 0x0F (ADD) -> no sh_stb, res_valid next cycle with res_err=1; res_ready held low 5 cycles -> outputs stable, in_ready=0.
REQ-028 rst asserted in WAIT, then sh_ack pulsed -> res_valid stays 0, in_ready=1; with SHIFT_TIMEOUT_EN and sh_ack tied low -> res_err=1 exactly TIMEOUT_CYCLES cycles after WAIT entry.

Source files
------------

// File: rtl/shift_dispatch_pkg.sv
// Shared eBPF shift-dispatch definitions: opcode field layout, class and
// op constants, the SRC bit position, field widths and the FSM state enum.
package shift_dispatch_pkg;

    localparam int unsigned XLEN      = 64;
    localparam int unsigned OPC_W     = 8;
    localparam int unsigned CLASS_W   = 3;
    localparam int unsigned OP_W      = 4;
    localparam int unsigned IMM_W     = 32;
    localparam int unsigned HALF_W    = 32;
    localparam int unsigned SHAMT64_W = 6;
    localparam int unsigned SHAMT32_W = 5;

    // opcode[3]: 1 selects src register, 0 selects sign-extended immediate
    localparam int unsigned SRC_BIT = 3;

    localparam logic [CLASS_W-1:0] CLASS_ALU32 = 3'h4;
    localparam logic [CLASS_W-1:0] CLASS_ALU64 = 3'h7;

    localparam logic [OP_W-1:0] OP_LSH  = 4'h6;
    localparam logic [OP_W-1:0] OP_RSH  = 4'h7;
    localparam logic [OP_W-1:0] OP_ARSH = 4'hC;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        DONE  = 2'd3
    } state_t;

endpackage

// File: rtl/shift_dispatch_if.sv
// Bundle of the instruction, shifter and result handshakes of shift_dispatch.
// master: instruction source / shifter / result consumer side.
// slave : the dispatch unit.
interface shift_dispatch_if
    import shift_dispatch_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = XLEN
);
    logic                  in_valid;
    logic                  in_ready;
    logic [OPC_W-1:0]      opcode;
    logic [DATA_WIDTH-1:0] dst_val;
    logic [DATA_WIDTH-1:0] src_val;
    logic [IMM_W-1:0]      imm;

    logic                  sh_stb;
    logic                  sh_arith;
    logic                  sh_left;
    logic [DATA_WIDTH-1:0] sh_value;
    logic [DATA_WIDTH-1:0] sh_shift;
    logic [DATA_WIDTH-1:0] sh_out;
    logic                  sh_ack;

    logic                  res_valid;
    logic                  res_ready;
    logic [DATA_WIDTH-1:0] res_data;
    logic                  res_err;

    modport master (
        output in_valid, opcode, dst_val, src_val, imm, sh_out, sh_ack, res_ready,
        input  in_ready, sh_stb, sh_arith, sh_left, sh_value, sh_shift,
               res_valid, res_data, res_err
    );

    modport slave (
        input  in_valid, opcode, dst_val, src_val, imm, sh_out, sh_ack, res_ready,
        output in_ready, sh_stb, sh_arith, sh_left, sh_value, sh_shift,
               res_valid, res_data, res_err
    );

endinterface

// File: rtl/shift_operand_prep.sv
// Combinational eBPF shift decode and operand/amount formation.
// Ports: opcode_i, dst_val_i, src_val_i, imm_i in; legal/alu32/left/arith
// flags and the shifter value/amount out (all combinational, _c).
module shift_operand_prep
    import shift_dispatch_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = XLEN
) (
    input  logic [OPC_W-1:0]      opcode_i,
    input  logic [DATA_WIDTH-1:0] dst_val_i,
    input  logic [DATA_WIDTH-1:0] src_val_i,
    input  logic [IMM_W-1:0]      imm_i,
    output logic                  legal_c_o,
    output logic                  alu32_c_o,
    output logic                  left_c_o,
    output logic                  arith_c_o,
    output logic [DATA_WIDTH-1:0] value_c_o,
    output logic [DATA_WIDTH-1:0] shift_c_o
);

    logic [CLASS_W-1:0]    cls;
    logic [OP_W-1:0]       op;
    logic [DATA_WIDTH-1:0] amount;
    logic                  unused_amount_bits;

    // Decode fields, then mask the amount and form the operand per class
    always_comb begin
        cls       = opcode_i[CLASS_W-1:0];
        op        = opcode_i[OPC_W-1 -: OP_W];
        alu32_c_o = (cls == CLASS_ALU32);
        left_c_o  = (op == OP_LSH);
        arith_c_o = (op == OP_ARSH);
        legal_c_o = (alu32_c_o || (cls == CLASS_ALU64)) &&
                    (left_c_o || arith_c_o || (op == OP_RSH));

        amount = opcode_i[SRC_BIT] ? src_val_i
                                   : {{(DATA_WIDTH-IMM_W){imm_i[IMM_W-1]}}, imm_i};

        if (alu32_c_o) begin
            shift_c_o = DATA_WIDTH'(amount[SHAMT32_W-1:0]);
            // ARSH on the low word needs the sign replicated into the upper half
            value_c_o = arith_c_o
                ? {{(DATA_WIDTH-HALF_W){dst_val_i[HALF_W-1]}}, dst_val_i[HALF_W-1:0]}
                : DATA_WIDTH'(dst_val_i[HALF_W-1:0]);
        end else begin
            shift_c_o = DATA_WIDTH'(amount[SHAMT64_W-1:0]);
            value_c_o = dst_val_i;
        end
    end

    assign unused_amount_bits = ^amount[DATA_WIDTH-1:SHAMT64_W];

endmodule

// File: rtl/shift_dispatch.sv
// eBPF shift instruction dispatcher: accepts LSH/RSH/ARSH (ALU32/ALU64),
// strobes an external shifter, waits for its ack and presents the result.
// Ports: clk, rst (sync, active-high), bus (shift_dispatch_if.slave).
// Optional: SHIFT_TIMEOUT_EN adds an ack watchdog of TIMEOUT_CYCLES cycles.
module shift_dispatch
    import shift_dispatch_pkg::*;
#(
    parameter int unsigned DATA_WIDTH     = XLEN,
    parameter int unsigned TIMEOUT_CYCLES = 16
) (
    input  logic           clk,
    input  logic           rst,
    shift_dispatch_if.slave bus
);

    logic                  legal_c, alu32_c, left_c, arith_c;
    logic [DATA_WIDTH-1:0] value_c, shift_c;

    state_t                state_q, state_d;
    logic                  in_ready_q, in_ready_d;
    logic                  sh_stb_q, sh_stb_d;
    logic                  sh_left_q, sh_left_d;
    logic                  sh_arith_q, sh_arith_d;
    logic [DATA_WIDTH-1:0] sh_value_q, sh_value_d;
    logic [DATA_WIDTH-1:0] sh_shift_q, sh_shift_d;
    logic                  alu32_q, alu32_d;
    logic                  res_valid_q, res_valid_d;
    logic [DATA_WIDTH-1:0] res_data_q, res_data_d;
    logic                  res_err_q, res_err_d;

`ifdef SHIFT_TIMEOUT_EN
    localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [CNT_W-1:0]      cnt_q, cnt_d;
`else
    localparam int unsigned TIMEOUT_UNUSED = TIMEOUT_CYCLES;
`endif

    shift_operand_prep #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_prep (
        .opcode_i  (bus.opcode),
        .dst_val_i (bus.dst_val),
        .src_val_i (bus.src_val),
        .imm_i     (bus.imm),
        .legal_c_o (legal_c),
        .alu32_c_o (alu32_c),
        .left_c_o  (left_c),
        .arith_c_o (arith_c),
        .value_c_o (value_c),
        .shift_c_o (shift_c)
    );

    // Next-state and registered-output logic
    always_comb begin
        state_d    = state_q;
        sh_left_d  = sh_left_q;
        sh_arith_d = sh_arith_q;
        sh_value_d = sh_value_q;
        sh_shift_d = sh_shift_q;
        alu32_d    = alu32_q;
        res_data_d = res_data_q;
        res_err_d  = res_err_q;
`ifdef SHIFT_TIMEOUT_EN
        cnt_d      = cnt_q;
`endif

        case (state_q)
            IDLE: begin
                if (bus.in_valid) begin
                    if (legal_c) begin
                        sh_left_d  = left_c;
                        sh_arith_d = arith_c;
                        sh_value_d = value_c;
                        sh_shift_d = shift_c;
                        alu32_d    = alu32_c;
                        state_d    = ISSUE;
                    end else begin
                        res_data_d = '0;
                        res_err_d  = 1'b1;
                        state_d    = DONE;
                    end
                end
            end
            ISSUE: begin
                state_d = WAIT;
`ifdef SHIFT_TIMEOUT_EN
                cnt_d   = '0;
`endif
            end
            WAIT: begin
                if (bus.sh_ack) begin
                    res_data_d = alu32_q
                        ? DATA_WIDTH'(bus.sh_out[HALF_W-1:0])
                        : bus.sh_out;
                    res_err_d  = 1'b0;
                    state_d    = DONE;
                end
`ifdef SHIFT_TIMEOUT_EN
                // cnt_q counts completed WAIT cycles without an ack
                else if (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
                    res_data_d = '0;
                    res_err_d  = 1'b1;
                    state_d    = DONE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
`endif
            end
            DONE: begin
                if (bus.res_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        // Handshake outputs are registered copies of the next state
        in_ready_d  = (state_d == IDLE);
        sh_stb_d    = (state_d == ISSUE);
        res_valid_d = (state_d == DONE);
    end

    // State and output registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            in_ready_q  <= 1'b1;
            sh_stb_q    <= 1'b0;
            sh_left_q   <= 1'b0;
            sh_arith_q  <= 1'b0;
            sh_value_q  <= '0;
            sh_shift_q  <= '0;
            alu32_q     <= 1'b0;
            res_valid_q <= 1'b0;
            res_data_q  <= '0;
            res_err_q   <= 1'b0;
`ifdef SHIFT_TIMEOUT_EN
            cnt_q       <= '0;
`endif
        end else begin
            state_q     <= state_d;
            in_ready_q  <= in_ready_d;
            sh_stb_q    <= sh_stb_d;
            sh_left_q   <= sh_left_d;
            sh_arith_q  <= sh_arith_d;
            sh_value_q  <= sh_value_d;
            sh_shift_q  <= sh_shift_d;
            alu32_q     <= alu32_d;
            res_valid_q <= res_valid_d;
            res_data_q  <= res_data_d;
            res_err_q   <= res_err_d;
`ifdef SHIFT_TIMEOUT_EN
            cnt_q       <= cnt_d;
`endif
        end
    end

    assign bus.in_ready  = in_ready_q;
    assign bus.sh_stb    = sh_stb_q;
    assign bus.sh_left   = sh_left_q;
    assign bus.sh_arith  = sh_arith_q;
    assign bus.sh_value  = sh_value_q;
    assign bus.sh_shift  = sh_shift_q;
    assign bus.res_valid = res_valid_q;
    assign bus.res_data  = res_data_q;
    assign bus.res_err   = res_err_q;

endmodule

// File: tb/tb_shift_dispatch.sv
// Directed self-checking bench for shift_dispatch with a 2-cycle shifter model.
module tb_shift_dispatch;

    localparam int unsigned TIMEOUT_CYCLES = 16;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    shift_dispatch_if #(.DATA_WIDTH(64)) bus();

    shift_dispatch #(
        .DATA_WIDTH     (64),
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    int checks = 0;
    int errors = 0;

    logic        shifter_en = 1'b1;
    logic        auto_ack   = 1'b0;
    logic        man_ack    = 1'b0;
    logic [63:0] auto_out   = '0;
    int          stb_count  = 0;

    assign bus.sh_ack = auto_ack | man_ack;
    assign bus.sh_out = auto_out;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Shifter model: sees the strobe, raises ack for one cycle two cycles later
    initial begin : shifter
        logic [63:0] v;
        logic [63:0] s;
        logic [63:0] r;
        forever begin
            @(posedge clk);
            #1;
            if (bus.sh_stb) begin
                stb_count++;
                if (shifter_en) begin
                    v = bus.sh_value;
                    s = bus.sh_shift;
                    if (bus.sh_left)       r = v << s;
                    else if (bus.sh_arith) r = 64'($signed(v) >>> s);
                    else                   r = v >> s;
                    @(posedge clk); #1;
                    @(posedge clk); #1;
                    auto_ack = 1'b1;
                    auto_out = r;
                    @(posedge clk); #1;
                    auto_ack = 1'b0;
                    auto_out = 64'hDEAD_BEEF_DEAD_BEEF;
                end
            end
        end
    end

    task automatic test_reset();
        rst          = 1'b1;
        bus.in_valid = 1'b1;
        bus.opcode   = 8'h6F;
        bus.dst_val  = 64'h1;
        bus.src_val  = 64'h43;
        bus.imm      = 32'h0;
        bus.res_ready = 1'b0;
        tick();
        tick();
        checks++;
        if ({bus.in_ready, bus.sh_stb, bus.res_valid, bus.res_err, bus.sh_left, bus.sh_arith} !== 6'b100000) begin
            errors++;
            $display("FAIL reset_flags: got %b expected 100000",
                     {bus.in_ready, bus.sh_stb, bus.res_valid, bus.res_err, bus.sh_left, bus.sh_arith});
        end
        checks++;
        if ({bus.res_data, bus.sh_value, bus.sh_shift} !== 192'h0) begin
            errors++;
            $display("FAIL reset_data: got %h %h %h expected zeros", bus.res_data, bus.sh_value, bus.sh_shift);
        end
        bus.in_valid = 1'b0;
        rst = 1'b0;
        tick();
        checks++;
        if (bus.in_ready !== 1'b1 || bus.sh_stb !== 1'b0) begin
            errors++;
            $display("FAIL reset_release: in_ready %b sh_stb %b expected 1 0", bus.in_ready, bus.sh_stb);
        end
    endtask

    // One legal shift with the standard-latency shifter; starts and ends in IDLE
    task automatic test_shift_op(input string name, input logic [7:0] opc,
                                 input logic [63:0] dst, input logic [63:0] src,
                                 input logic [31:0] im,
                                 input logic [63:0] exp_value, input logic [63:0] exp_shift,
                                 input logic exp_left, input logic exp_arith,
                                 input logic [63:0] exp_data);
        bus.opcode    = opc;
        bus.dst_val   = dst;
        bus.src_val   = src;
        bus.imm       = im;
        bus.res_ready = 1'b1;
        bus.in_valid  = 1'b1;
        tick();
        bus.in_valid  = 1'b0;
        bus.dst_val   = '1;
        bus.src_val   = '1;
        checks++;
        if (bus.sh_stb !== 1'b1 || bus.in_ready !== 1'b0) begin
            errors++;
            $display("FAIL %s issue: sh_stb %b in_ready %b expected 1 0", name, bus.sh_stb, bus.in_ready);
        end
        checks++;
        if (bus.sh_value !== exp_value || bus.sh_shift !== exp_shift ||
            bus.sh_left !== exp_left || bus.sh_arith !== exp_arith) begin
            errors++;
            $display("FAIL %s operands: got v=%h s=%h l=%b a=%b expected v=%h s=%h l=%b a=%b",
                     name, bus.sh_value, bus.sh_shift, bus.sh_left, bus.sh_arith,
                     exp_value, exp_shift, exp_left, exp_arith);
        end
        tick();
        checks++;
        if (bus.sh_stb !== 1'b0 || bus.sh_value !== exp_value || bus.sh_shift !== exp_shift) begin
            errors++;
            $display("FAIL %s wait_hold: sh_stb %b v=%h s=%h expected 0 v=%h s=%h",
                     name, bus.sh_stb, bus.sh_value, bus.sh_shift, exp_value, exp_shift);
        end
        tick();
        checks++;
        if (bus.res_valid !== 1'b0) begin
            errors++;
            $display("FAIL %s early_valid: res_valid %b expected 0", name, bus.res_valid);
        end
        tick();
        checks++;
        if (bus.res_valid !== 1'b1 || bus.res_err !== 1'b0 || bus.res_data !== exp_data) begin
            errors++;
            $display("FAIL %s result: valid %b err %b data %h expected 1 0 %h",
                     name, bus.res_valid, bus.res_err, bus.res_data, exp_data);
        end
        tick();
        checks++;
        if (bus.res_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
            errors++;
            $display("FAIL %s return_idle: res_valid %b in_ready %b expected 0 1",
                     name, bus.res_valid, bus.in_ready);
        end
        bus.res_ready = 1'b0;
    endtask

    task automatic test_illegal();
        int stb_before;
        stb_before    = stb_count;
        bus.opcode    = 8'h0F;
        bus.dst_val   = 64'h5;
        bus.src_val   = 64'h1;
        bus.res_ready = 1'b0;
        bus.in_valid  = 1'b1;
        tick();
        bus.in_valid  = 1'b0;
        checks++;
        if (bus.res_valid !== 1'b1 || bus.res_err !== 1'b1 || bus.res_data !== 64'h0 || bus.sh_stb !== 1'b0) begin
            errors++;
            $display("FAIL illegal_add: valid %b err %b data %h stb %b expected 1 1 0 0",
                     bus.res_valid, bus.res_err, bus.res_data, bus.sh_stb);
        end
        for (int i = 0; i < 5; i++) begin
            tick();
            checks++;
            if (bus.res_valid !== 1'b1 || bus.res_err !== 1'b1 || bus.res_data !== 64'h0 ||
                bus.in_ready !== 1'b0 || bus.sh_stb !== 1'b0) begin
                errors++;
                $display("FAIL illegal_hold%0d: valid %b err %b data %h in_ready %b stb %b expected 1 1 0 0 0",
                         i, bus.res_valid, bus.res_err, bus.res_data, bus.in_ready, bus.sh_stb);
            end
        end
        bus.res_ready = 1'b1;
        tick();
        bus.res_ready = 1'b0;
        checks++;
        if (bus.res_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
            errors++;
            $display("FAIL illegal_release: valid %b in_ready %b expected 0 1", bus.res_valid, bus.in_ready);
        end
        // Illegal class (5) with a legal op field
        bus.opcode   = 8'h65;
        bus.in_valid = 1'b1;
        tick();
        bus.in_valid = 1'b0;
        checks++;
        if (bus.res_valid !== 1'b1 || bus.res_err !== 1'b1 || bus.sh_stb !== 1'b0) begin
            errors++;
            $display("FAIL illegal_class: valid %b err %b stb %b expected 1 1 0",
                     bus.res_valid, bus.res_err, bus.sh_stb);
        end
        bus.res_ready = 1'b1;
        tick();
        bus.res_ready = 1'b0;
        tick();
        checks++;
        if (stb_count !== stb_before) begin
            errors++;
            $display("FAIL illegal_no_stb: strobes %0d expected %0d", stb_count, stb_before);
        end
    endtask

    task automatic test_reset_in_wait();
        shifter_en    = 1'b0;
        bus.opcode    = 8'h6F;
        bus.dst_val   = 64'h1;
        bus.src_val   = 64'h43;
        bus.res_ready = 1'b1;
        bus.in_valid  = 1'b1;
        tick();
        bus.in_valid  = 1'b0;
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        man_ack = 1'b1;
        tick();
        man_ack = 1'b0;
        checks++;
        if (bus.res_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
            errors++;
            $display("FAIL late_ack: res_valid %b in_ready %b expected 0 1", bus.res_valid, bus.in_ready);
        end
        tick();
        checks++;
        if (bus.res_valid !== 1'b0 || bus.sh_stb !== 1'b0 || bus.in_ready !== 1'b1) begin
            errors++;
            $display("FAIL late_ack_after: valid %b stb %b in_ready %b expected 0 0 1",
                     bus.res_valid, bus.sh_stb, bus.in_ready);
        end
        bus.res_ready = 1'b0;
        shifter_en = 1'b1;
    endtask

    task automatic test_timeout();
        int early;
        early         = 0;
        shifter_en    = 1'b0;
        bus.opcode    = 8'h6F;
        bus.dst_val   = 64'h1;
        bus.src_val   = 64'h43;
        bus.res_ready = 1'b0;
        bus.in_valid  = 1'b1;
        tick();
        bus.in_valid  = 1'b0;
        tick();
`ifdef SHIFT_TIMEOUT_EN
        // WAIT entered at the previous edge; result due TIMEOUT_CYCLES edges later
        for (int i = 1; i < TIMEOUT_CYCLES; i++) begin
            tick();
            if (bus.res_valid !== 1'b0) early++;
        end
        checks++;
        if (early != 0) begin
            errors++;
            $display("FAIL timeout_early: res_valid seen in %0d cycles expected 0", early);
        end
        tick();
        checks++;
        if (bus.res_valid !== 1'b1 || bus.res_err !== 1'b1 || bus.res_data !== 64'h0) begin
            errors++;
            $display("FAIL timeout_fire: valid %b err %b data %h expected 1 1 0",
                     bus.res_valid, bus.res_err, bus.res_data);
        end
        bus.res_ready = 1'b1;
        tick();
        bus.res_ready = 1'b0;
        checks++;
        if (bus.in_ready !== 1'b1) begin
            errors++;
            $display("FAIL timeout_release: in_ready %b expected 1", bus.in_ready);
        end
`else
        for (int i = 0; i < 40; i++) begin
            tick();
            if (bus.res_valid !== 1'b0 || bus.in_ready !== 1'b0) early++;
        end
        checks++;
        if (early != 0) begin
            errors++;
            $display("FAIL wait_hold_forever: left WAIT in %0d cycles expected 0", early);
        end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        tick();
`endif
        shifter_en = 1'b1;
    endtask

    initial begin
        rst           = 1'b1;
        bus.in_valid  = 1'b0;
        bus.opcode    = '0;
        bus.dst_val   = '0;
        bus.src_val   = '0;
        bus.imm       = '0;
        bus.res_ready = 1'b0;

        test_reset();
        test_shift_op("alu64_lsh_reg", 8'h6F, 64'h1, 64'h43, 32'h0,
                      64'h1, 64'h3, 1'b1, 1'b0, 64'h8);
        test_shift_op("alu32_arsh_imm", 8'hC4, 64'hFFFF_FFFF_8000_0000, 64'h0, 32'h4,
                      64'hFFFF_FFFF_8000_0000, 64'h4, 1'b0, 1'b1, 64'h0000_0000_F800_0000);
        test_shift_op("alu32_rsh_reg", 8'h7C, 64'hAAAA_AAAA_0000_0010, 64'h24, 32'h0,
                      64'h10, 64'h4, 1'b0, 1'b0, 64'h1);
        test_shift_op("alu64_arsh_imm_neg", 8'hC7, 64'h8000_0000_0000_0000, 64'h0, 32'hFFFF_FFFF,
                      64'h8000_0000_0000_0000, 64'd63, 1'b0, 1'b1, 64'hFFFF_FFFF_FFFF_FFFF);
        test_shift_op("alu32_lsh_imm_trunc", 8'h64, 64'h1234_5678_8000_0001, 64'h0, 32'h21,
                      64'h8000_0001, 64'h1, 1'b1, 1'b0, 64'h2);
        test_illegal();
        test_reset_in_wait();
        test_timeout();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
